// File: rtl/id_bubble_tracker_pkg.sv
// Shared definitions for the IF/ID bubble tracker: bubble encoding, FSM states and strobes.
package id_bubble_tracker_pkg;

   localparam int unsigned INSTR_W      = 32;
   localparam int unsigned CNT_W_DEF    = 16;
   localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h2000_0000;

   // Encodings are shared with the IF no-op inserter; keep them fixed.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_JR_A = 2'd1,
      ST_JR_B = 2'd2,
      ST_LW_A = 2'd3
   } bubble_state_e;

   typedef struct packed {
      logic bubble;
      logic err;
   } fsm_strobe_t;

   function automatic logic flags_illegal(input logic no_op, input logic pre_no_op);
      return no_op & pre_no_op;
   endfunction

endpackage

// File: rtl/id_bubble_tracker_bubble_fsm.sv
// Bubble-sequence FSM: tracks the IF flag protocol and emits per-capture bubble/error strobes.
module id_bubble_tracker_bubble_fsm
   import id_bubble_tracker_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        adv,
   input  logic        no_op,
   input  logic        pre_no_op,
   input  logic        instr_is_nop,
   output fsm_strobe_t strobe_c
);

   bubble_state_e state_q;
   bubble_state_e state_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and strobes; only meaningful on non-stalled captures.
   always_comb begin
      state_d         = state_q;
      strobe_c.bubble = 1'b0;
      strobe_c.err    = 1'b0;
      if (adv) begin
         if (flags_illegal(no_op, pre_no_op)) begin
            strobe_c.err = 1'b1;
            state_d      = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (pre_no_op) begin
                     state_d         = ST_JR_A;
                     strobe_c.bubble = 1'b1;
                  end else if (no_op) begin
                     state_d = ST_LW_A;
                  end
               end
               ST_JR_A: begin
                  if (no_op) begin
                     state_d = ST_JR_B;
                  end else begin
                     state_d      = ST_IDLE;
                     strobe_c.err = 1'b1;
                  end
               end
               ST_JR_B, ST_LW_A: begin
                  state_d = ST_IDLE;
                  if (!no_op && !pre_no_op && instr_is_nop) begin
                     strobe_c.bubble = 1'b1;
                  end else begin
                     strobe_c.err = 1'b1;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/id_bubble_tracker.sv
// IF/ID pipeline register that mirrors the IF no-op flags back and tracks inserted bubbles.
module id_bubble_tracker
   import id_bubble_tracker_pkg::*;
#(
   parameter int unsigned      WIDTH     = INSTR_W,
   parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(NOP_INSTR_DEF),
   parameter int unsigned      CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] IF_instr,
   input  logic [WIDTH-1:0] IF_pc,
   input  logic             IF_noOp,
   input  logic             IF_prenoOp,
   input  logic             ID_stall,
   output logic [WIDTH-1:0] ID_instr,
   output logic [WIDTH-1:0] ID_pc,
   output logic             ID_noOp,
   output logic             ID_preNoOp,
   output logic             ID_bubble,
   output logic             protocol_err,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   fsm_strobe_t strobe_c;
   logic        adv_c;

   logic [WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             no_op_q, no_op_d;
   logic             pre_no_op_q, pre_no_op_d;
   logic             bubble_q, bubble_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign adv_c = ~ID_stall;

   id_bubble_tracker_bubble_fsm u_bubble_fsm (
      .clk          (clk),
      .reset        (reset),
      .adv          (adv_c),
      .no_op        (IF_noOp),
      .pre_no_op    (IF_prenoOp),
      .instr_is_nop (IF_instr == NOP_INSTR),
      .strobe_c     (strobe_c)
   );

   // Capture on non-stalled cycles, otherwise hold everything.
   always_comb begin
      instr_d     = instr_q;
      pc_d        = pc_q;
      no_op_d     = no_op_q;
      pre_no_op_d = pre_no_op_q;
      bubble_d    = bubble_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      if (adv_c) begin
         instr_d     = IF_instr;
         pc_d        = IF_pc;
         no_op_d     = IF_noOp;
         pre_no_op_d = IF_prenoOp;
         bubble_d    = strobe_c.bubble;
         err_d       = err_q | strobe_c.err;
         if (strobe_c.bubble && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q     <= NOP_INSTR;
         pc_q        <= '0;
         no_op_q     <= 1'b0;
         pre_no_op_q <= 1'b0;
         bubble_q    <= 1'b1;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         no_op_q     <= no_op_d;
         pre_no_op_q <= pre_no_op_d;
         bubble_q    <= bubble_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ID_instr     = instr_q;
   assign ID_pc        = pc_q;
   assign ID_noOp      = no_op_q;
   assign ID_preNoOp   = pre_no_op_q;
   assign ID_bubble    = bubble_q;
   assign protocol_err = err_q;
   assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_bubble_tracker.sv
// Directed bench for id_bubble_tracker; a second instance with CNT_W=2 covers saturation.
module tb_id_bubble_tracker;

   localparam logic [31:0] NOP  = 32'h2000_0000;
   localparam logic [31:0] JR   = 32'h03FF_FFC8;
   localparam logic [31:0] LW   = 32'h8FFF_FFC8;
   localparam logic [31:0] ADDI = 32'h23FF_FFC8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_instr, if_pc;
   logic        if_no_op, if_pre_no_op, id_stall;

   logic [31:0] id_instr, id_pc;
   logic        id_no_op, id_pre_no_op, id_bubble, prot_err;
   logic [15:0] bubble_cnt;

   logic [31:0] s_instr, s_pc;
   logic        s_no_op, s_pre_no_op, s_bubble, s_err;
   logic [1:0]  s_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_bubble_tracker dut (
      .clk(clk), .reset(reset), .IF_instr(if_instr), .IF_pc(if_pc),
      .IF_noOp(if_no_op), .IF_prenoOp(if_pre_no_op), .ID_stall(id_stall),
      .ID_instr(id_instr), .ID_pc(id_pc), .ID_noOp(id_no_op), .ID_preNoOp(id_pre_no_op),
      .ID_bubble(id_bubble), .protocol_err(prot_err), .bubble_cnt(bubble_cnt)
   );

   id_bubble_tracker #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .IF_instr(if_instr), .IF_pc(if_pc),
      .IF_noOp(if_no_op), .IF_prenoOp(if_pre_no_op), .ID_stall(id_stall),
      .ID_instr(s_instr), .ID_pc(s_pc), .ID_noOp(s_no_op), .ID_preNoOp(s_pre_no_op),
      .ID_bubble(s_bubble), .protocol_err(s_err), .bubble_cnt(s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic pre, input logic nop);
      if_instr     = instr;
      if_pc        = pc;
      if_pre_no_op = pre;
      if_no_op     = nop;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      id_stall = 1'b0;
      drive(32'h0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      chk("rst_instr", id_instr, NOP);
      chk("rst_pc", id_pc, 32'h0);
      chk("rst_bubble", 32'(id_bubble), 32'd1);
      chk("rst_flags", 32'({id_no_op, id_pre_no_op}), 32'd0);
      chk("rst_cnt", 32'(bubble_cnt), 32'd0);
      chk("rst_err", 32'(prot_err), 32'd0);
      reset = 1'b0;

      // JR sequence
      drive(NOP, 32'h100, 1'b1, 1'b0); step();
      chk("jr1_pre", 32'(id_pre_no_op), 32'd1);
      chk("jr1_bubble", 32'(id_bubble), 32'd1);
      chk("jr1_pc", id_pc, 32'h100);
      drive(JR, 32'h104, 1'b0, 1'b1); step();
      chk("jr2_noop", 32'(id_no_op), 32'd1);
      chk("jr2_bubble", 32'(id_bubble), 32'd0);
      chk("jr2_instr", id_instr, JR);
      drive(NOP, 32'h108, 1'b0, 1'b0); step();
      chk("jr3_bubble", 32'(id_bubble), 32'd1);
      chk("jr_cnt", 32'(bubble_cnt), 32'd2);
      chk("jr_err", 32'(prot_err), 32'd0);

      // LW sequence then a plain ADDI
      drive(LW, 32'h200, 1'b0, 1'b1); step();
      chk("lw1_noop", 32'(id_no_op), 32'd1);
      chk("lw1_bubble", 32'(id_bubble), 32'd0);
      drive(NOP, 32'h204, 1'b0, 1'b0); step();
      chk("lw2_bubble", 32'(id_bubble), 32'd1);
      chk("lw_cnt", 32'(bubble_cnt), 32'd3);
      drive(ADDI, 32'h208, 1'b0, 1'b0); step();
      chk("addi_bubble", 32'(id_bubble), 32'd0);
      chk("addi_instr", id_instr, ADDI);
      chk("addi_cnt", 32'(bubble_cnt), 32'd3);
      chk("sat_early", 32'(s_cnt), 32'd3);

      // Stall in JR_A; illegal flags while stalled must be ignored
      drive(NOP, 32'h300, 1'b1, 1'b0); step();
      chk("st_enter_cnt", 32'(bubble_cnt), 32'd4);
      id_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(32'hDEAD_0000 + 32'(i), 32'h400 + 32'(i), 1'b1, 1'b1); step();
         chk("st_instr", id_instr, NOP);
         chk("st_pc", id_pc, 32'h300);
         chk("st_flags", 32'({id_no_op, id_pre_no_op, id_bubble}), 32'b011);
         chk("st_cnt", 32'(bubble_cnt), 32'd4);
         chk("st_err", 32'(prot_err), 32'd0);
      end
      id_stall = 1'b0;
      drive(JR, 32'h304, 1'b0, 1'b1); step();
      chk("st_jr2_bubble", 32'(id_bubble), 32'd0);
      drive(NOP, 32'h308, 1'b0, 1'b0); step();
      chk("st_jr3_bubble", 32'(id_bubble), 32'd1);
      chk("st_done_cnt", 32'(bubble_cnt), 32'd5);
      chk("st_done_err", 32'(prot_err), 32'd0);

      // Protocol error is sticky until reset
      drive(ADDI, 32'h500, 1'b1, 1'b1); step();
      chk("pe_err", 32'(prot_err), 32'd1);
      chk("pe_bubble", 32'(id_bubble), 32'd0);
      chk("pe_cnt", 32'(bubble_cnt), 32'd5);
      for (int i = 0; i < 10; i++) begin
         drive(ADDI, 32'h504 + 32'(4 * i), 1'b0, 1'b0); step();
         chk("pe_sticky", 32'(prot_err), 32'd1);
      end
      chk("pe_capture", id_pc, 32'h528);
      reset = 1'b1; step();
      chk("pe_rst_err", 32'(prot_err), 32'd0);
      chk("pe_rst_cnt", 32'(bubble_cnt), 32'd0);
      chk("pe_rst_sat", 32'(s_cnt), 32'd0);
      reset = 1'b0;

      // Saturation on the 2-bit counter
      for (int i = 0; i < 5; i++) begin
         drive(LW, 32'h600, 1'b0, 1'b1); step();
         drive(NOP, 32'h604, 1'b0, 1'b0); step();
         chk("sat_cnt", 32'(s_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
         chk("wide_cnt", 32'(bubble_cnt), 32'(i + 1));
      end
      chk("sat_err", 32'(s_err), 32'd0);

      // Reset during LW_A aborts the sequence without error
      drive(LW, 32'h700, 1'b0, 1'b1); step();
      reset = 1'b1; step();
      reset = 1'b0;
      drive(ADDI, 32'h704, 1'b0, 1'b0); step();
      chk("abort_err", 32'(prot_err), 32'd0);
      chk("abort_bubble", 32'(id_bubble), 32'd0);
      chk("abort_cnt", 32'(bubble_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
